gpio_port: RTL and testbench
============================

# gpio_port

Parametrised memory-mapped GPIO peripheral and successor to the chip-level 8-bit output latch. It sits on the `proc` I/O bus (`addr`/`data_out`/`data_in`/`io_en`) and provides:
- per-pin direction control;
- atomic set/clear/toggle of the output register;
- synchronised pin input;
- edge-triggered interrupt status, which can be compiled out.

## Interface
- `WIDTH`, 8: number of GPIO pins, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `io_en`  in  1  bus access strobe, one cycle per access.
- `we`  in  1  1 = write, 0 = read, qualified by `io_en`.
- `addr`  in  4  word offset of the register.
- `data_out`  in  32  write data from CPU; bits above `WIDTH` are ignored.
- `data_in`  out  32  registered read data, zero-extended.
- `rvalid`  out  1  one-cycle pulse, `data_in` valid.
- `gpio_in`  in  `WIDTH`  asynchronous pin inputs.
- `gpio_out`  out  `WIDTH`  output register.
- `gpio_oe`  out  `WIDTH`  output enable; equals the DIR register.
- `irq`  out  1  interrupt: OR of (STATUS & IRQ_EN).

## Operation
Register map (`addr`):
- 0x0 OUT: R/W.
- 0x1 DIR: R/W; 1 = output.
- 0x2 IN: read-only; last synchroniser stage.
- 0x3 SET: write-only; OUT |= wdata.
- 0x4 CLR: write-only; OUT &= ~wdata.
- 0x5 TGL: write-only; OUT ^= wdata.
- 0x6 IRQ_EN: R/W.
- 0x7 IRQ_RISE: R/W; 1 = rising edge, 0 = falling edge, per pin.
- 0x8 STATUS: read returns the status bits; write-1-to-clear.
- Unmapped addresses and write-only registers read 0. Writes to unmapped addresses and to IN are ignored.

Behaviour:
- Write: register updates on the `clk` edge where `io_en & we`. Only one access per cycle.
- Read: on `io_en & ~we`, `data_in` captures the register value and `rvalid` = 1 on the following cycle. Otherwise `rvalid` = 0 and `data_in` holds its last value.
- Synchroniser: `SYNC_STAGES` flops per pin. A previous-sample register `prev` holds the last synchroniser output.
- Edge detect: rise = sync & ~prev; fall = ~sync & prev. A STATUS bit sets when IRQ_EN[i] = 1 and the selected edge occurs.
- Simultaneous W1C and new edge on the same bit: the set wins.
- IRQ_EN = 0 does not clear existing STATUS bits.
- `irq` is combinational from registers and is glitch-free relative to `clk`.
- Simultaneous pin change and IN read: the read returns the pre-edge synchroniser value.

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - OUT, DIR, IRQ_EN, STATUS, `data_in`, all synchroniser stages and `prev` to 0;
  - IRQ_RISE to all-ones;
  - outputs `gpio_out` = 0, `gpio_oe` = 0, `irq` = 0, `rvalid` = 0, `data_in` = 0.
- Reset asserted mid-access aborts the access. No `rvalid` follows deassertion.
- Write latency: `gpio_out`/`gpio_oe` change 1 cycle after the write strobe edge.
- Read latency: 1 cycle (`rvalid` in the cycle after `io_en`).
- Input latency: a pin change is visible in IN `SYNC_STAGES` cycles after the first sampling edge. STATUS sets 1 cycle after IN changes. `irq` rises in the same cycle as STATUS.
- A pulse shorter than one `clk` period may be missed; no guarantee is made.
- W1C takes effect 1 cycle after the strobe; `irq` deasserts in that same cycle unless another bit remains set.

## Configuration
- Macro `GPIO_PORT_IRQ_EN`.
- Defined: IRQ_EN, IRQ_RISE, STATUS, the edge detector and `irq` are implemented as described.
- Undefined:
  - those registers are absent; addresses 0x6–0x8 read 0 and ignore writes;
  - `irq` is tied to 0;
  - `prev` is not instantiated.
- The port list is identical in both builds.

## Test plan
- Reset: drive `rst` = 0 mid-write of OUT = 0xFF -> `gpio_out` = 0x00, `gpio_oe` = 0x00, `irq` = 0, no `rvalid`; read IRQ_RISE -> 0xFF.
- Atomic ops: write OUT = 0x0F, SET 0x30, CLR 0x03, TGL 0x81 -> `gpio_out` steps 0x0F, 0x3F, 0x3C, 0xBD, each 1 cycle after its strobe.
- Direction and read-back: write DIR = 0xA5 -> `gpio_oe` = 0xA5; read DIR -> `data_in` = 0x000000A5 with `rvalid` pulse 1 cycle later; read addr 0xF -> 0.
- Synchroniser: `gpio_in` 0x00 -> 0x12, then read IN every cycle -> 0x12 first returned exactly `SYNC_STAGES` (+1 read) cycles after the change.
- Interrupt (macro defined):
  - IRQ_EN = 0x01, IRQ_RISE = 0x00, pin 0 high then low -> STATUS = 0x01, `irq` = 1;
  - write STATUS 0x01 in the same cycle as a new falling edge -> STATUS stays 0x01.
- Macro undefined: toggle all pins with IRQ_EN written 0xFF -> `irq` remains 0; reads of 0x6–0x8 return 0.

Source files
------------

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO with per-pin direction, atomic set/clear/toggle,
// synchronised inputs and optional edge-triggered interrupt status.
// Optional feature macro: GPIO_PORT_IRQ_EN (defined = IRQ_EN, IRQ_RISE, STATUS,
// edge detector and irq present; undefined = addresses 0x6-0x8 read 0, irq = 0).
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_en,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      data_out,
  output logic [31:0]      data_in,
  output logic             rvalid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] ADDR_OUT = 4'h0;
  localparam logic [3:0] ADDR_DIR = 4'h1;
  localparam logic [3:0] ADDR_IN  = 4'h2;
  localparam logic [3:0] ADDR_SET = 4'h3;
  localparam logic [3:0] ADDR_CLR = 4'h4;
  localparam logic [3:0] ADDR_TGL = 4'h5;
`ifdef GPIO_PORT_IRQ_EN
  localparam logic [3:0] ADDR_IRQ_EN   = 4'h6;
  localparam logic [3:0] ADDR_IRQ_RISE = 4'h7;
  localparam logic [3:0] ADDR_STATUS   = 4'h8;
`endif

  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] rd_val;
  logic             unused_data;

  assign wr_acc = io_en & we;
  assign rd_acc = io_en & ~we;
  assign wdata  = data_out[WIDTH-1:0];
  assign in_val = sync_q[SYNC_STAGES-1];

  // Upper write-data bits beyond WIDTH are intentionally dropped.
  assign unused_data = ^data_out;

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

  // Input synchroniser chain; the last stage is the IN register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Output register with direct write and atomic set/clear/toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (wr_acc) begin
      case (addr)
        ADDR_OUT: out_q <= wdata;
        ADDR_SET: out_q <= out_q | wdata;
        ADDR_CLR: out_q <= out_q & ~wdata;
        ADDR_TGL: out_q <= out_q ^ wdata;
        default:  out_q <= out_q;
      endcase
    end
  end

  // Direction register; drives the pin output enables directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q <= '0;
    end else if (wr_acc && addr == ADDR_DIR) begin
      dir_q <= wdata;
    end
  end

`ifdef GPIO_PORT_IRQ_EN
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_rise_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] w1c;

  assign edge_hit = irq_en_q & ((irq_rise_q & in_val & ~prev_q) |
                                (~irq_rise_q & ~in_val & prev_q));
  assign w1c      = (wr_acc && addr == ADDR_STATUS) ? wdata : '0;

  // irq is a pure function of flops, so it only changes right after clk edges.
  assign irq = |(status_q & irq_en_q);

  // Interrupt configuration registers; IRQ_RISE resets to rising-edge on all pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_q   <= '0;
      irq_rise_q <= '1;
    end else if (wr_acc) begin
      if (addr == ADDR_IRQ_EN)   irq_en_q   <= wdata;
      if (addr == ADDR_IRQ_RISE) irq_rise_q <= wdata;
    end
  end

  // Edge history and sticky status; a new edge beats a same-cycle W1C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= '0;
      status_q <= '0;
    end else begin
      prev_q   <= in_val;
      status_q <= (status_q & ~w1c) | edge_hit;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux; write-only and unmapped locations return zero.
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_OUT: rd_val = out_q;
      ADDR_DIR: rd_val = dir_q;
      ADDR_IN:  rd_val = in_val;
`ifdef GPIO_PORT_IRQ_EN
      ADDR_IRQ_EN:   rd_val = irq_en_q;
      ADDR_IRQ_RISE: rd_val = irq_rise_q;
      ADDR_STATUS:   rd_val = status_q;
`endif
      default:  rd_val = '0;
    endcase
  end

  // Registered read port: data captured on the access edge, rvalid one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_in <= '0;
      rvalid  <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc) data_in <= 32'(rd_val);
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// Testbench for gpio_port: directed table, hand-written corner sequences and a
// randomized phase checked against a register-level reference model.
module tb_gpio_port;

  localparam int W = 8;
  localparam int S = 2;
  localparam logic [31:0] MASK = 32'h0000_00FF;
`ifdef GPIO_PORT_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         io_en;
  logic         we;
  logic [3:0]   addr;
  logic [31:0]  data_out;
  logic [31:0]  data_in;
  logic         rvalid;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .io_en(io_en), .we(we), .addr(addr),
    .data_out(data_out), .data_in(data_in), .rvalid(rvalid),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  // Reference model state
  logic [31:0] m_out, m_dir, m_en, m_rise, m_stat, m_data, m_prev;
  bit          m_rvalid;
  logic [31:0] pin_q[$];

  typedef struct {
    logic        io;
    logic        wr;
    logic [3:0]  a;
    logic [31:0] d;
    logic [7:0]  e_out;
    logic [7:0]  e_oe;
    logic        e_rv;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [31:0] m_read(input logic [3:0] a, input logic [31:0] in_cur);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      4'h0: r = m_out;
      4'h1: r = m_dir;
      4'h2: r = in_cur;
      4'h6: r = HAS_IRQ ? m_en : 32'h0;
      4'h7: r = HAS_IRQ ? m_rise : 32'h0;
      4'h8: r = HAS_IRQ ? m_stat : 32'h0;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_en = 0; m_stat = 0; m_data = 0; m_prev = 0;
    m_rise = HAS_IRQ ? MASK : 32'h0;
    m_rvalid = 1'b0;
    pin_q = {};
    for (int i = 0; i < S; i++) pin_q.push_back(32'h0);
  endtask

  // Advance the model by one clk edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] in_cur, w, hits;
    in_cur = pin_q[0];
    w = data_out & MASK;
    hits = m_en & MASK & ((m_rise & in_cur & ~m_prev) | (~m_rise & ~in_cur & m_prev));
    m_rvalid = io_en && !we;
    if (m_rvalid) m_data = m_read(addr, in_cur);
    if (io_en && we) begin
      case (addr)
        4'h0: m_out = w;
        4'h1: m_dir = w;
        4'h3: m_out = m_out | w;
        4'h4: m_out = m_out & ~w;
        4'h5: m_out = m_out ^ w;
        4'h6: if (HAS_IRQ) m_en = w;
        4'h7: if (HAS_IRQ) m_rise = w;
        4'h8: if (HAS_IRQ) m_stat = m_stat & ~w;
        default: ;
      endcase
    end
    if (HAS_IRQ) m_stat = m_stat | hits;
    m_prev = in_cur;
    pin_q.push_back(32'(gpio_in));
    void'(pin_q.pop_front());
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic i, input logic w, input logic [3:0] a, input logic [31:0] d);
    io_en = i; we = w; addr = a; data_out = d;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    check("rnd_gpio_out", 32'(gpio_out), m_out);
    check("rnd_gpio_oe", 32'(gpio_oe), m_dir);
    check("rnd_rvalid", 32'(rvalid), 32'(m_rvalid));
    check("rnd_data_in", data_in, m_data);
    check("rnd_irq", 32'(irq), HAS_IRQ ? 32'(|(m_stat & m_en)) : 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 4'h0, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 4'h0, 32'h0000_000F, 8'h0F, 8'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 4'h3, 32'h0000_0030, 8'h3F, 8'h00, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 4'h4, 32'hFFFF_FF03, 8'h3C, 8'h00, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 4'h5, 32'h0000_0081, 8'hBD, 8'h00, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 4'h1, 32'h0000_00A5, 8'hBD, 8'hA5, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 4'h1, 32'h0,         8'hBD, 8'hA5, 1'b1, 32'h0000_00A5};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 32'h0,         8'hBD, 8'hA5, 1'b1, 32'h0000_00BD};
    tbl[7]  = '{1'b1, 1'b0, 4'hF, 32'h0,         8'hBD, 8'hA5, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 4'h0, 32'h0,         8'hBD, 8'hA5, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 4'h2, 32'h0000_00FF, 8'hBD, 8'hA5, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 4'h3, 32'h0,         8'hBD, 8'hA5, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 4'h7, 32'h0,         8'hBD, 8'hA5, 1'b1, HAS_IRQ ? 32'hFF : 32'h0};

    rst = 1'b0;
    gpio_in = '0;
    drive(0, 0, 4'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_gpio_out", 32'(gpio_out), 32'h0);
    check("reset_gpio_oe", 32'(gpio_oe), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_data_in", data_in, 32'h0);
    rst = 1'b1;

    // Directed table: atomic ops, direction, read-back, unmapped and write-only reads
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].io, tbl[i].wr, tbl[i].a, tbl[i].d);
      step();
      check($sformatf("tbl%0d_gpio_out", i), 32'(gpio_out), 32'(tbl[i].e_out));
      check($sformatf("tbl%0d_gpio_oe", i), 32'(gpio_oe), 32'(tbl[i].e_oe));
      check($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].e_rv));
      check($sformatf("tbl%0d_data_in", i), data_in, tbl[i].e_data);
    end

    // Reset asserted in the middle of an OUT write
    drive(1, 1, 4'h0, 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst_gpio_out", 32'(gpio_out), 32'h0);
    check("midrst_gpio_oe", 32'(gpio_oe), 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    drive(0, 0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_rvalid", 32'(rvalid), 32'h0);
    check("postrst_gpio_out", 32'(gpio_out), 32'h0);
    drive(1, 0, 4'h7, 32'h0);
    step();
    check("postrst_irq_rise", data_in, HAS_IRQ ? 32'hFF : 32'h0);

    // Synchroniser latency: read IN every cycle after a pin change
    drive(1, 0, 4'h2, 32'h0);
    gpio_in = 8'h12;
    for (int c = 1; c <= S + 3; c++) begin
      step();
      check($sformatf("sync_c%0d", c), data_in, (c >= S + 1) ? 32'h12 : 32'h0);
    end
    drive(0, 0, 4'h0, 32'h0);

`ifdef GPIO_PORT_IRQ_EN
    drive(1, 1, 4'h6, 32'h01); step();
    drive(1, 1, 4'h7, 32'h00); step();
    drive(0, 0, 4'h0, 32'h0);
    gpio_in = 8'h13;
    repeat (S + 2) step();
    check("irq_rise_ignored", 32'(irq), 32'h0);
    gpio_in = 8'h12;
    repeat (S + 2) step();
    check("irq_fall_set", 32'(irq), 32'h1);
    drive(1, 0, 4'h8, 32'h0); step();
    check("status_after_fall", data_in, 32'h1);
    drive(1, 1, 4'h8, 32'h1); step();
    check("w1c_clears_irq", 32'(irq), 32'h0);
    drive(0, 0, 4'h0, 32'h0);
    gpio_in = 8'h13;
    repeat (S + 2) step();
    gpio_in = 8'h12;
    repeat (S) step();
    check("pre_collide_irq", 32'(irq), 32'h0);
    drive(1, 1, 4'h8, 32'h1); step();
    check("collide_irq", 32'(irq), 32'h1);
    drive(1, 0, 4'h8, 32'h0); step();
    check("collide_status", data_in, 32'h1);
    drive(1, 1, 4'h6, 32'h0); step();
    check("en_off_irq", 32'(irq), 32'h0);
    drive(1, 0, 4'h8, 32'h0); step();
    check("en_off_status_kept", data_in, 32'h1);
    drive(0, 0, 4'h0, 32'h0);
`else
    drive(1, 1, 4'h6, 32'hFF); step();
    drive(1, 1, 4'h7, 32'h00); step();
    drive(0, 0, 4'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      gpio_in = ~gpio_in;
      step();
      check($sformatf("noirq_toggle%0d", k), 32'(irq), 32'h0);
    end
    for (int a = 6; a <= 8; a++) begin
      drive(1, 0, 4'(a), 32'h0);
      step();
      check($sformatf("noirq_read%0d", a), data_in, 32'h0);
      check($sformatf("noirq_rvalid%0d", a), 32'(rvalid), 32'h1);
    end
    drive(0, 0, 4'h0, 32'h0);
`endif

    // Randomized accesses and pin activity against the reference model
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
      step();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
